// File: rtl/fft_pkg.sv
// Shared constants and elaboration-time helpers for the FFT stage control logic.
// This package builds the quarter-wave cosine table and provides the log2 helper.
package fft_pkg;

  localparam int FRAC = 10;

  function automatic int log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // round(2^frac_bits * cos(2*pi*j/n)) for j in 0..n/4. The argument stays in
  // [0, pi/2], so a Taylor series is accurate, and the value is never negative.
  // Adding one half before truncating therefore rounds half away from zero.
  function automatic int quarter_cos(input int n, input int frac_bits, input int j);
    real x;
    real term;
    real sum;
    real scale;
    x = 2.0 * 3.14159265358979323846 * real'(j) / real'(n);
    term = 1.0;
    sum = 1.0;
    for (int i = 1; i <= 12; i++) begin
      term = -term * x * x / real'((2 * i - 1) * (2 * i));
      sum = sum + term;
    end
    scale = 1.0;
    for (int i = 0; i < frac_bits; i++) scale = scale * 2.0;
    return $rtoi(sum * scale + 0.5);
  endfunction

endpackage

// File: rtl/twiddle_rom.sv
// Quarter-wave twiddle lookup: k in 0..N/2-1 maps to c = cos and s = -sin,
// both in Q-format, by folding k onto the table Q[0..N/4].
module twiddle_rom
  import fft_pkg::*;
#(
  parameter int width = 12,
  parameter int frac  = FRAC,
  parameter int N     = 16,
  localparam int KW   = log2(N) - 1
) (
  input  logic [KW-1:0]    k,
  output logic [width-1:0] c,
  output logic [width-1:0] s
);

  localparam int QN = N / 4;
  localparam logic [KW-1:0] QTR = KW'(QN);

  logic signed [width-1:0] q_tab [0:QN];

  for (genvar j = 0; j <= QN; j++) begin : g_tab
    assign q_tab[j] = width'(quarter_cos(N, frac, j));
  end

  logic [KW-1:0] ci;
  logic [KW-1:0] si;
  logic          upper;

  always_comb begin
    upper = (k > QTR);
    ci    = k;
    si    = QTR - k;
    if (upper) begin
      // N/2 == 2**KW, so N/2 - k is simply -k in KW bits.
      ci = -k;
      si = k - QTR;
    end
    c = upper ? -q_tab[ci] : q_tab[ci];
    s = -q_tab[si];
  end

endmodule

// File: rtl/twiddle_sequencer.sv
// Tracks the word-serial complex stream of one FFT stage and emits the rotator's
// cosine/sine coefficients and re/im select, registered one cycle after each word.
module twiddle_sequencer
  import fft_pkg::*;
#(
  parameter int width     = 12,
  parameter int frac      = FRAC,
  parameter int N         = 16,
  parameter int stage_idx = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             sof,
  output logic [width-1:0] c,
  output logic [width-1:0] s,
  output logic             sel_1,
  output logic             out_valid,
  output logic             resync
);

  localparam int LN   = log2(N);
  localparam int KW   = LN - 1;
  localparam int SH   = stage_idx - 1;
  localparam int L    = N >> SH;
  localparam int HALF = L / 2;
  localparam logic [width-1:0] ONE = width'(1 << frac);

  // The identity coefficient 2^frac must fit in a signed width-bit word.
  if (frac > width - 2) begin : g_bad_frac
    $error("twiddle_sequencer: 2^frac does not fit in width signed bits");
  end

  // Handshake: a word is accepted on every clock edge where in_valid is high
  // (there is no backpressure); out_valid marks the registered result of the
  // word accepted on the previous edge, and the coefficient outputs hold otherwise.
  logic [LN:0]      wc_q, wc_d;
  logic [width-1:0] c_q, c_d;
  logic [width-1:0] s_q, s_d;
  logic             sel_q, sel_d;
  logic             ov_q, ov_d;
  logic             rs_q, rs_d;

  logic [LN:0]      wc_eff;
  logic [LN-1:0]    n;
  logic [LN-1:0]    p;
  logic [KW-1:0]    k;
  logic [width-1:0] rom_c;
  logic [width-1:0] rom_s;

  twiddle_rom #(
    .width (width),
    .frac  (frac),
    .N     (N)
  ) u_rom (
    .k (k),
    .c (rom_c),
    .s (rom_s)
  );

  always_comb begin
    // A qualified sof forces this word to position 0 of a frame.
    wc_eff = (in_valid && sof) ? '0 : wc_q;
    n      = wc_eff[LN:1];
    p      = n & LN'(L - 1);
    if (p < LN'(HALF)) k = '0;
    else               k = KW'((p - LN'(HALF)) << SH);
  end

  always_comb begin
    wc_d  = wc_q;
    c_d   = c_q;
    s_d   = s_q;
    sel_d = sel_q;
    ov_d  = 1'b0;
    rs_d  = 1'b0;
    if (in_valid) begin
      // Counter width makes 2N-1 + 1 wrap to 0 without any sof.
      wc_d  = wc_eff + 1'b1;
      c_d   = rom_c;
      s_d   = rom_s;
      sel_d = wc_eff[0];
      ov_d  = 1'b1;
      rs_d  = sof && (wc_q != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wc_q  <= '0;
      c_q   <= ONE;
      s_q   <= '0;
      sel_q <= 1'b0;
      ov_q  <= 1'b0;
      rs_q  <= 1'b0;
    end else begin
      wc_q  <= wc_d;
      c_q   <= c_d;
      s_q   <= s_d;
      sel_q <= sel_d;
      ov_q  <= ov_d;
      rs_q  <= rs_d;
    end
  end

  assign c         = c_q;
  assign s         = s_q;
  assign sel_1     = sel_q;
  assign out_valid = ov_q;
  assign resync    = rs_q;

endmodule
